// File: rtl/mem_axi_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
// State encodings and AXI response codes live here.
package mem_axi_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [2:0] {
    MEM_ARB_IDLE    = 3'd0,
    MEM_ARB_RD_ADDR = 3'd1,
    MEM_ARB_RD_DATA = 3'd2,
    MEM_ARB_WR_REQ  = 3'd3,
    MEM_ARB_WR_RESP = 3'd4
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_axi_arbiter_rr2.sv
// Two-way round-robin pick between IFU (req[0]) and LSU (req[1]).
// A tie goes to whichever side was not served last.
module mem_axi_arbiter_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last_lsu,
  output logic       o_pick_lsu
);

  assign o_pick_lsu = i_req[1] & (~i_req[0] | ~i_last_lsu);

endmodule

// File: rtl/mem_axi_arbiter.sv
// Serializes IFU reads and LSU reads/writes onto one AXI-lite slave.
// Writes win in IDLE; reads alternate between IFU and LSU.
module mem_axi_arbiter
  import mem_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ifu_arvalid,
  input  logic [ADDR_W-1:0]   i_ifu_araddr,
  output logic                o_ifu_arready,
  output logic                o_ifu_rvalid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic [1:0]          o_ifu_rresp,
  input  logic                i_ifu_rready,
  input  logic                i_lsu_arvalid,
  input  logic [ADDR_W-1:0]   i_lsu_araddr,
  output logic                o_lsu_arready,
  output logic                o_lsu_rvalid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic [1:0]          o_lsu_rresp,
  input  logic                i_lsu_rready,
  input  logic                i_lsu_awvalid,
  input  logic [ADDR_W-1:0]   i_lsu_awaddr,
  output logic                o_lsu_awready,
  input  logic                i_lsu_wvalid,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  output logic                o_lsu_wready,
  output logic                o_lsu_bvalid,
  output logic [1:0]          o_lsu_bresp,
  input  logic                i_lsu_bready,
  output logic                o_s_arvalid,
  output logic [ADDR_W-1:0]   o_s_araddr,
  input  logic                i_s_arready,
  input  logic                i_s_rvalid,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  output logic                o_s_rready,
  output logic                o_s_awvalid,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  input  logic                i_s_awready,
  output logic                o_s_wvalid,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  input  logic                i_s_wready,
  input  logic                i_s_bvalid,
  input  logic [1:0]          i_s_bresp,
  output logic                o_s_bready
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic r_grant_lsu;
  logic r_last_rd_lsu;
  logic r_aw_done;
  logic r_w_done;

  logic w_pick_lsu;
  logic w_wr_req;
  logic w_rd_req;
  logic w_m_rready;
  logic w_ar_fire;
  logic w_r_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_wr_both;
  logic w_b_fire;

  mem_axi_arbiter_rr2 u_rr2 (
    .i_req      ({i_lsu_arvalid, i_ifu_arvalid}),
    .i_last_lsu (r_last_rd_lsu),
    .o_pick_lsu (w_pick_lsu)
  );

  assign w_wr_req   = i_lsu_awvalid & i_lsu_wvalid;
  assign w_rd_req   = i_ifu_arvalid | i_lsu_arvalid;
  assign w_m_rready = r_grant_lsu ? i_lsu_rready : i_ifu_rready;
  assign w_ar_fire  = o_s_arvalid & i_s_arready;
  assign w_r_fire   = i_s_rvalid & o_s_rready;
  assign w_aw_fire  = o_s_awvalid & i_s_awready;
  assign w_w_fire   = o_s_wvalid & i_s_wready;
  assign w_b_fire   = i_s_bvalid & o_s_bready;
  // Both halves of the write may land on the same edge.
  assign w_wr_both  = (r_aw_done | w_aw_fire) &
                      (r_w_done | w_w_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= MEM_ARB_IDLE;
      r_grant_lsu   <= 1'b0;
      r_last_rd_lsu <= 1'b1;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == MEM_ARB_IDLE && !w_wr_req && w_rd_req)
        r_grant_lsu <= w_pick_lsu;
      if (r_state == MEM_ARB_RD_DATA && w_r_fire)
        r_last_rd_lsu <= r_grant_lsu;
      if (r_state == MEM_ARB_WR_REQ && w_wr_both) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MEM_ARB_IDLE: begin
        if (w_wr_req)      w_state_nxt = MEM_ARB_WR_REQ;
        else if (w_rd_req) w_state_nxt = MEM_ARB_RD_ADDR;
      end
      MEM_ARB_RD_ADDR:
        if (w_ar_fire) w_state_nxt = MEM_ARB_RD_DATA;
      MEM_ARB_RD_DATA:
        if (w_r_fire) w_state_nxt = MEM_ARB_IDLE;
      MEM_ARB_WR_REQ:
        if (w_wr_both) w_state_nxt = MEM_ARB_WR_RESP;
      MEM_ARB_WR_RESP:
        if (w_b_fire) w_state_nxt = MEM_ARB_IDLE;
      default: w_state_nxt = MEM_ARB_IDLE;
    endcase
  end

  always_comb begin
    o_ifu_arready = 1'b0;
    o_ifu_rvalid  = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = AXI_RESP_OKAY;
    o_lsu_arready = 1'b0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = AXI_RESP_OKAY;
    o_lsu_awready = 1'b0;
    o_lsu_wready  = 1'b0;
    o_lsu_bvalid  = 1'b0;
    o_lsu_bresp   = AXI_RESP_OKAY;
    o_s_arvalid   = 1'b0;
    o_s_araddr    = '0;
    o_s_rready    = 1'b0;
    o_s_awvalid   = 1'b0;
    o_s_awaddr    = '0;
    o_s_wvalid    = 1'b0;
    o_s_wdata     = '0;
    o_s_wstrb     = '0;
    o_s_bready    = 1'b0;
    unique case (r_state)
      MEM_ARB_RD_ADDR: begin
        o_s_arvalid   = 1'b1;
        o_s_araddr    = r_grant_lsu ? i_lsu_araddr
                                    : i_ifu_araddr;
        o_lsu_arready = r_grant_lsu & i_s_arready;
        o_ifu_arready = ~r_grant_lsu & i_s_arready;
      end
      MEM_ARB_RD_DATA: begin
        o_s_rready = w_m_rready;
        if (r_grant_lsu) begin
          o_lsu_rvalid = i_s_rvalid;
          o_lsu_rdata  = i_s_rdata;
          o_lsu_rresp  = i_s_rresp;
        end else begin
          o_ifu_rvalid = i_s_rvalid;
          o_ifu_rdata  = i_s_rdata;
          o_ifu_rresp  = i_s_rresp;
        end
      end
      MEM_ARB_WR_REQ: begin
        o_s_awvalid   = ~r_aw_done;
        o_s_awaddr    = i_lsu_awaddr;
        o_s_wvalid    = ~r_w_done;
        o_s_wdata     = i_lsu_wdata;
        o_s_wstrb     = i_lsu_wstrb;
        o_lsu_awready = i_s_awready & ~r_aw_done;
        o_lsu_wready  = i_s_wready & ~r_w_done;
      end
      MEM_ARB_WR_RESP: begin
        o_s_bready   = i_lsu_bready;
        o_lsu_bvalid = i_s_bvalid;
        o_lsu_bresp  = i_s_bresp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Bench for mem_axi_arbiter: directed latency/reset cases plus
// random rounds checked against a transaction-order model.
module tb_mem_axi_arbiter;
  import mem_axi_arbiter_pkg::*;

  localparam int AW = ARB_ADDR_W;
  localparam int DW = ARB_DATA_W;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_ifu_arvalid, o_ifu_arready;
  logic [AW-1:0] i_ifu_araddr;
  logic          o_ifu_rvalid, i_ifu_rready;
  logic [DW-1:0] o_ifu_rdata;
  logic [1:0]    o_ifu_rresp;
  logic          i_lsu_arvalid, o_lsu_arready;
  logic [AW-1:0] i_lsu_araddr;
  logic          o_lsu_rvalid, i_lsu_rready;
  logic [DW-1:0] o_lsu_rdata;
  logic [1:0]    o_lsu_rresp;
  logic          i_lsu_awvalid, o_lsu_awready;
  logic [AW-1:0] i_lsu_awaddr;
  logic          i_lsu_wvalid, o_lsu_wready;
  logic [DW-1:0] i_lsu_wdata;
  logic [SW-1:0] i_lsu_wstrb;
  logic          o_lsu_bvalid, i_lsu_bready;
  logic [1:0]    o_lsu_bresp;
  logic          o_s_arvalid, i_s_arready;
  logic [AW-1:0] o_s_araddr;
  logic          i_s_rvalid, o_s_rready;
  logic [DW-1:0] i_s_rdata;
  logic [1:0]    i_s_rresp;
  logic          o_s_awvalid, i_s_awready;
  logic [AW-1:0] o_s_awaddr;
  logic          o_s_wvalid, i_s_wready;
  logic [DW-1:0] o_s_wdata;
  logic [SW-1:0] o_s_wstrb;
  logic          i_s_bvalid, o_s_bready;
  logic [1:0]    i_s_bresp;

  mem_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .i_ifu_arvalid(i_ifu_arvalid), .i_ifu_araddr(i_ifu_araddr),
    .o_ifu_arready(o_ifu_arready),
    .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
    .o_ifu_rresp(o_ifu_rresp), .i_ifu_rready(i_ifu_rready),
    .i_lsu_arvalid(i_lsu_arvalid), .i_lsu_araddr(i_lsu_araddr),
    .o_lsu_arready(o_lsu_arready),
    .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_rresp(o_lsu_rresp), .i_lsu_rready(i_lsu_rready),
    .i_lsu_awvalid(i_lsu_awvalid), .i_lsu_awaddr(i_lsu_awaddr),
    .o_lsu_awready(o_lsu_awready),
    .i_lsu_wvalid(i_lsu_wvalid), .i_lsu_wdata(i_lsu_wdata),
    .i_lsu_wstrb(i_lsu_wstrb), .o_lsu_wready(o_lsu_wready),
    .o_lsu_bvalid(o_lsu_bvalid), .o_lsu_bresp(o_lsu_bresp),
    .i_lsu_bready(i_lsu_bready),
    .o_s_arvalid(o_s_arvalid), .o_s_araddr(o_s_araddr),
    .i_s_arready(i_s_arready),
    .i_s_rvalid(i_s_rvalid), .i_s_rdata(i_s_rdata),
    .i_s_rresp(i_s_rresp), .o_s_rready(o_s_rready),
    .o_s_awvalid(o_s_awvalid), .o_s_awaddr(o_s_awaddr),
    .i_s_awready(i_s_awready),
    .o_s_wvalid(o_s_wvalid), .o_s_wdata(o_s_wdata),
    .o_s_wstrb(o_s_wstrb), .i_s_wready(i_s_wready),
    .i_s_bvalid(i_s_bvalid), .i_s_bresp(i_s_bresp),
    .o_s_bready(o_s_bready)
  );

  logic [11:0] w_hs;
  assign w_hs = {o_ifu_arready, o_ifu_rvalid, o_lsu_arready,
                 o_lsu_rvalid, o_lsu_awready, o_lsu_wready,
                 o_lsu_bvalid, o_s_arvalid, o_s_rready,
                 o_s_awvalid, o_s_wvalid, o_s_bready};

  // A master may not withdraw a request before it is accepted.
  a_ifu_ar: assert property (@(posedge clk) disable iff (rst)
    i_ifu_arvalid && !o_ifu_arready |=> i_ifu_arvalid);
  a_lsu_ar: assert property (@(posedge clk) disable iff (rst)
    i_lsu_arvalid && !o_lsu_arready |=> i_lsu_arvalid);
  a_lsu_aw: assert property (@(posedge clk) disable iff (rst)
    i_lsu_awvalid && !o_lsu_awready |=> i_lsu_awvalid);
  a_lsu_w: assert property (@(posedge clk) disable iff (rst)
    i_lsu_wvalid && !o_lsu_wready |=> i_lsu_wvalid);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_ifu_arvalid = 0; i_ifu_araddr = '0; i_ifu_rready = 0;
    i_lsu_arvalid = 0; i_lsu_araddr = '0; i_lsu_rready = 0;
    i_lsu_awvalid = 0; i_lsu_awaddr = '0;
    i_lsu_wvalid = 0; i_lsu_wdata = '0; i_lsu_wstrb = '0;
    i_lsu_bready = 0;
    i_s_arready = 0; i_s_rvalid = 0; i_s_rdata = '0;
    i_s_rresp = '0; i_s_awready = 0; i_s_wready = 0;
    i_s_bvalid = 0; i_s_bresp = '0;
  endtask

  // kind: 0 IFU read, 1 LSU read, 2 LSU write, 3 nothing expected
  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } txn_t;

  bit model_last_lsu;

  task automatic run_round(input int mode);
    bit want_i, want_l, want_w;
    int wd, cyc;
    txn_t ti, tl, tw, h;
    txn_t rd[$];
    txn_t q[$];
    bit i_pend, l_pend, aw_pend, w_pend;
    bit s_rbusy, s_rv, s_awg, s_wg, s_bv;
    logic [AW-1:0] s_raddr;
    logic [1:0] s_rr, s_br;
    int aw_cnt, w_cnt;

    want_i = ($urandom_range(0, 1) == 1);
    want_l = ($urandom_range(0, 1) == 1);
    want_w = ($urandom_range(0, 1) == 1);
    wd = $urandom_range(0, 2);
    if (!want_i && !want_l && !want_w) want_i = 1;
    if (mode == 1) begin
      want_i = 1; want_l = 1; want_w = 0;
    end
    ti = '0; tl = '0; tw = '0;
    ti.kind = 2'd0; ti.addr = {$urandom} & ~32'h7;
    tl.kind = 2'd1; tl.addr = {$urandom} & ~32'h7;
    tw.kind = 2'd2; tw.addr = {$urandom} & ~32'h7;
    tw.data = {$urandom, $urandom};
    tw.strb = 8'($urandom_range(0, 255));
    if (mode == 2) begin
      want_i = 1; want_l = 0; want_w = 1; wd = 0;
      tw.addr = 32'h8000_1000;
      tw.data = 64'hDEAD_BEEF;
      tw.strb = 8'h0F;
    end

    // Expected slave-side order from arbitration rules.
    if (want_i && want_l) begin
      if (model_last_lsu) begin rd.push_back(ti); rd.push_back(tl); end
      else begin rd.push_back(tl); rd.push_back(ti); end
    end else if (want_i) rd.push_back(ti);
    else if (want_l) rd.push_back(tl);
    if (rd.size() > 0) model_last_lsu = (rd[rd.size()-1].kind == 2'd1);
    if (want_w && (wd == 0 || rd.size() == 0)) begin
      q.push_back(tw);
      foreach (rd[k]) q.push_back(rd[k]);
    end else if (want_w) begin
      // W arrives late, so a read slips in first.
      q.push_back(rd[0]);
      q.push_back(tw);
      for (int k = 1; k < rd.size(); k++) q.push_back(rd[k]);
    end else begin
      foreach (rd[k]) q.push_back(rd[k]);
    end

    i_pend = want_i; l_pend = want_l;
    aw_pend = want_w; w_pend = want_w;
    s_rbusy = 0; s_rv = 0; s_awg = 0; s_wg = 0; s_bv = 0;
    s_raddr = '0; s_rr = '0; s_br = '0;
    aw_cnt = 0; w_cnt = 0; cyc = 0;

    while (q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      i_ifu_arvalid = i_pend; i_ifu_araddr = ti.addr;
      i_lsu_arvalid = l_pend; i_lsu_araddr = tl.addr;
      i_lsu_awvalid = aw_pend; i_lsu_awaddr = tw.addr;
      i_lsu_wvalid = w_pend && (cyc >= wd);
      i_lsu_wdata = tw.data; i_lsu_wstrb = tw.strb;
      i_ifu_rready = ($urandom_range(0, 3) != 0);
      i_lsu_rready = ($urandom_range(0, 3) != 0);
      i_lsu_bready = ($urandom_range(0, 3) != 0);
      i_s_arready = ($urandom_range(0, 2) != 0);
      i_s_awready = ($urandom_range(0, 1) == 1);
      i_s_wready = ($urandom_range(0, 1) == 1);
      if (s_rbusy && !s_rv && $urandom_range(0, 2) != 0) s_rv = 1;
      i_s_rvalid = s_rv;
      i_s_rdata = {s_raddr, ~s_raddr};
      i_s_rresp = s_rr;
      if (s_awg && s_wg && !s_bv && $urandom_range(0, 2) != 0)
        s_bv = 1;
      i_s_bvalid = s_bv;
      i_s_bresp = s_br;
      #1;
      h = '0; h.kind = 2'd3;
      if (q.size() > 0) h = q[0];

      if (o_s_arvalid && i_s_arready) begin
        check("ar", 128'({o_lsu_arready, o_ifu_arready,
                          s_rbusy | s_awg | s_wg, o_s_araddr}),
                    128'({h.kind == 2'd1, h.kind == 2'd0,
                          1'b0, h.addr}));
        s_rbusy = 1; s_raddr = o_s_araddr;
        s_rr = 2'($urandom_range(0, 3));
        if (i_ifu_arvalid && o_ifu_arready) i_pend = 0;
        if (i_lsu_arvalid && o_lsu_arready) l_pend = 0;
      end
      if (i_s_rvalid && o_s_rready) begin
        check("r", 128'({o_ifu_rvalid, o_lsu_rvalid,
                         h.kind == 2'd1 ? o_lsu_rdata : o_ifu_rdata,
                         h.kind == 2'd1 ? o_lsu_rresp : o_ifu_rresp}),
                   128'({h.kind == 2'd0, h.kind == 2'd1,
                         h.addr, ~h.addr, s_rr}));
        s_rbusy = 0; s_rv = 0;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (o_s_awvalid && i_s_awready) begin
        check("aw", 128'({o_lsu_awready, s_rbusy, o_s_awaddr}),
                    128'({h.kind == 2'd2, 1'b0, h.addr}));
        aw_cnt++; s_awg = 1;
        if (i_lsu_awvalid && o_lsu_awready) aw_pend = 0;
      end
      if (o_s_wvalid && i_s_wready) begin
        check("w", 128'({o_lsu_wready, o_s_wdata, o_s_wstrb}),
                   128'({h.kind == 2'd2, h.data, h.strb}));
        w_cnt++; s_wg = 1;
        if (i_lsu_wvalid && o_lsu_wready) w_pend = 0;
      end
      if (i_s_bvalid && o_s_bready) begin
        check("b", 128'({o_lsu_bvalid, o_lsu_bresp,
                         8'(aw_cnt), 8'(w_cnt)}),
                   128'({h.kind == 2'd2, s_br, 8'd1, 8'd1}));
        s_awg = 0; s_wg = 0; s_bv = 0;
        s_br = 2'($urandom_range(0, 3));
        aw_cnt = 0; w_cnt = 0;
        if (q.size() > 0) void'(q.pop_front());
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check("round_done", 128'(q.size()), 128'(0));
    if (q.size() > 0) begin
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_last_lsu = 1;
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    // Noisy slave/master inputs must not leak out during reset.
    i_s_arready = 1; i_s_rvalid = 1; i_s_rdata = '1;
    i_s_rresp = 2'b11; i_s_bvalid = 1; i_s_bresp = 2'b11;
    i_ifu_rready = 1; i_lsu_rready = 1; i_lsu_bready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hs", 128'(w_hs), 128'(0));
    check("rst_saddr", 128'({o_s_araddr, o_s_awaddr}), 128'(0));
    check("rst_sdata", 128'({o_s_wdata, o_s_wstrb}), 128'(0));
    check("rst_ifu", 128'({o_ifu_rdata, o_ifu_rresp}), 128'(0));
    check("rst_lsu", 128'({o_lsu_rdata, o_lsu_rresp,
                           o_lsu_bresp}), 128'(0));
    @(negedge clk);
    rst = 0;
    idle_inputs();

    @(negedge clk);
    i_ifu_arvalid = 1; i_ifu_araddr = 32'h8000_0000;
    i_s_arready = 1; i_ifu_rready = 1;
    #1 check("lat_t0", 128'(o_s_arvalid), 128'(0));
    @(negedge clk);
    #1 check("lat_t1", 128'({o_s_arvalid, o_ifu_arready,
                             o_lsu_arready, o_s_araddr}),
                       128'({3'b110, 32'h8000_0000}));
    @(negedge clk);
    i_ifu_arvalid = 0; i_s_arready = 0;
    i_s_rvalid = 1; i_s_rdata = 64'h1122_3344_5566_7788;
    i_s_rresp = AXI_RESP_OKAY;
    #1 check("lat_t2", 128'({o_ifu_rvalid, o_lsu_rvalid,
                             o_s_rready, o_ifu_rdata}),
                       128'({3'b101, 64'h1122_3344_5566_7788}));
    @(negedge clk);
    idle_inputs();
    #1 check("lat_t3", 128'(w_hs), 128'(0));

    @(negedge clk);
    i_ifu_arvalid = 1; i_ifu_araddr = 32'h8000_0040;
    i_s_arready = 1; i_ifu_rready = 1;
    @(negedge clk);
    @(negedge clk);
    i_ifu_arvalid = 0; i_s_arready = 0;
    #1 check("mid_rd", 128'({o_s_rready, o_ifu_rvalid}),
                       128'(2'b10));
    rst = 1;
    @(negedge clk);
    rst = 0;
    i_s_rvalid = 1; i_s_arready = 1; i_s_bvalid = 1;
    #1 check("mid_rst", 128'(w_hs), 128'(0));
    idle_inputs();

    model_last_lsu = 1;
    run_round(1);
    run_round(1);
    run_round(2);
    for (int r = 0; r < 80; r++) run_round(0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
